tmds_line_packer: RTL and testbench



---
 rtl/tmds_line_packer.sv | 174 +++++++++++++++++
 tb/tb_tmds_line_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_line_packer.sv
// tmds_line_packer
//   Cuts each active video line into SEG_PIX-pixel segments and writes one
//   header word per segment followed by 2-pixel data words into a packet FIFO.
//   The FIFO write cannot stall the pixel stream. If the FIFO is full when a
//   word is due, the rest of that segment is discarded and drop_cnt counts it.
//
// Ports
//   rx0_pclk    pixel clock, all logic on rising edge
//   rstbtn_n    asynchronous active-low reset
//   video_en    active pixel strobe, one pixel per cycle while high
//   video_vcnt  active line number, captured into the header at segment start
//   rx0_red/green/blue  pixel components, packed as {red,green,blue}
//   fifo_full   FIFO programmable-full, sampled in the deciding cycle
//   fifo_wr_en  registered FIFO write strobe
//   fifo_din    registered FIFO write data
//   seg_idx     index of the segment currently being packed
//   drop_cnt    saturating count of dropped segments
//
// States
//   IDLE | waiting for a rising edge of video_en
//   HDR  | header written, no data word yet in this segment
//   DATA | at least one data word written in this segment
//   DROP | segment discarded, no writes until next segment start or line end

module tmds_line_packer #(
  parameter int unsigned SEG_PIX   = 640,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        rx0_pclk,
  input  logic        rstbtn_n,
  input  logic        video_en,
  input  logic [10:0] video_vcnt,
  input  logic [7:0]  rx0_red,
  input  logic [7:0]  rx0_green,
  input  logic [7:0]  rx0_blue,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [47:0] fifo_din,
  output logic [3:0]  seg_idx,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0] SEG_LEN  = 11'(SEG_PIX);
  localparam logic [10:0] SEG_LAST = 11'(SEG_PIX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [23:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [3:0]  seg_idx_q, seg_idx_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [47:0] din_q, din_d;
  logic        en_prev_q;

  logic [23:0] pixel;
  logic        en_rise;
  logic        en_fall;
  logic        seg_start;
  logic        drop_inc;

  assign pixel   = {rx0_red, rx0_green, rx0_blue};
  assign en_rise = video_en & ~en_prev_q;
  assign en_fall = ~video_en & en_prev_q;

  // Outside IDLE a wrapped pixel counter with video_en still high means the
  // previous segment just ended, so this pixel opens the next one directly.
  assign seg_start = video_en & ((state_q == IDLE) ? en_rise : (pix_cnt_q == 11'd0));

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q      <= IDLE;
      pix_cnt_q    <= 11'd0;
      hold_q       <= 24'd0;
      hold_valid_q <= 1'b0;
      seg_idx_q    <= 4'd0;
      drop_cnt_q   <= 16'd0;
      wr_en_q      <= 1'b0;
      din_q        <= 48'd0;
      // Treat video_en as already high so a line in progress at reset release
      // is ignored until video_en falls and rises again.
      en_prev_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      seg_idx_q    <= seg_idx_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      en_prev_q    <= video_en;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    seg_idx_d    = seg_idx_q;
    drop_cnt_d   = drop_cnt_q;
    wr_en_d      = 1'b0;
    din_d        = din_q;
    drop_inc     = 1'b0;

    if (en_fall) begin
      // Odd-length tail: flush the held pixel in the high half.
      if (hold_valid_q && (state_q != DROP)) begin
        if (!fifo_full) begin
          wr_en_d = 1'b1;
          din_d   = {hold_q, 24'h0};
        end else begin
          drop_inc = 1'b1;
        end
      end
      state_d      = IDLE;
      seg_idx_d    = 4'd0;
      pix_cnt_d    = 11'd0;
      hold_valid_d = 1'b0;
    end else if (seg_start) begin
      hold_d       = pixel;
      hold_valid_d = 1'b1;
      pix_cnt_d    = 11'd1;
      if (!fifo_full) begin
        wr_en_d = 1'b1;
        din_d   = {SYNC_BYTE, video_vcnt, seg_idx_q, SEG_LEN, 14'h0};
        state_d = HDR;
      end else begin
        drop_inc = 1'b1;
        state_d  = DROP;
      end
    end else if (video_en && (state_q != IDLE)) begin
      if (pix_cnt_q == SEG_LAST) begin
        pix_cnt_d = 11'd0;
        seg_idx_d = seg_idx_q + 4'd1;
      end else begin
        pix_cnt_d = pix_cnt_q + 11'd1;
      end
      if (state_q != DROP) begin
        if (!pix_cnt_q[0]) begin
          hold_d       = pixel;
          hold_valid_d = 1'b1;
        end else if (!fifo_full) begin
          wr_en_d      = 1'b1;
          din_d        = {hold_q, pixel};
          hold_valid_d = 1'b0;
          state_d      = DATA;
        end else begin
          drop_inc     = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = DROP;
        end
      end
    end

    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign seg_idx    = seg_idx_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_tmds_line_packer.sv
module tb_tmds_line_packer;

  logic        clk = 1'b0;
  logic        clk_s = 1'b0;
  logic        rstbtn_n;
  logic        video_en;
  logic [10:0] video_vcnt;
  logic [7:0]  rx0_red, rx0_green, rx0_blue;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [47:0] fifo_din;
  logic [3:0]  seg_idx;
  logic [15:0] drop_cnt;

  // second instance with 2-pixel segments, used to reach drop_cnt saturation
  logic        video_en_s;
  logic        fifo_wr_en_s;
  logic [47:0] fifo_din_s;
  logic [3:0]  seg_idx_s;
  logic [15:0] drop_cnt_s;

  int passed = 0;
  int total  = 0;
  int wr_cnt = 0;
  int wr_cnt_s = 0;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;
  always #2 clk_s = ~clk_s;

  tmds_line_packer #(.SEG_PIX(640), .SYNC_BYTE(8'hA5)) dut (
    .rx0_pclk   (clk),
    .rstbtn_n   (rstbtn_n),
    .video_en   (video_en),
    .video_vcnt (video_vcnt),
    .rx0_red    (rx0_red),
    .rx0_green  (rx0_green),
    .rx0_blue   (rx0_blue),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .seg_idx    (seg_idx),
    .drop_cnt   (drop_cnt)
  );

  tmds_line_packer #(.SEG_PIX(2), .SYNC_BYTE(8'hA5)) dut_sat (
    .rx0_pclk   (clk_s),
    .rstbtn_n   (rstbtn_n),
    .video_en   (video_en_s),
    .video_vcnt (11'd0),
    .rx0_red    (8'd0),
    .rx0_green  (8'd0),
    .rx0_blue   (8'd0),
    .fifo_full  (1'b1),
    .fifo_wr_en (fifo_wr_en_s),
    .fifo_din   (fifo_din_s),
    .seg_idx    (seg_idx_s),
    .drop_cnt   (drop_cnt_s)
  );

  function automatic logic [47:0] hdr(input int vc, input int sg);
    return {8'hA5, 11'(vc), 4'(sg), 11'd640, 14'd0};
  endfunction

  // scoreboard: every DUT write is popped and compared against the queue
  always @(negedge clk) begin
    if (rstbtn_n && fifo_wr_en) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got %h, required no write", fifo_din);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if (fifo_din !== e) $display("FAIL write_data: got %h, required %h", fifo_din, e);
        else passed++;
      end
    end
  end

  always @(negedge clk_s) if (rstbtn_n && fifo_wr_en_s) wr_cnt_s++;

  task automatic drive_line(input int n, input int vc, input int full_idx);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      video_en   = 1'b1;
      video_vcnt = 11'(vc);
      {rx0_red, rx0_green, rx0_blue} = 24'(i);
      fifo_full  = (i == full_idx);
    end
    @(posedge clk); #1;
    video_en  = 1'b0;
    fifo_full = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstbtn_n = 1'b0;
    video_en = 1'b0; video_vcnt = '0; fifo_full = 1'b0; video_en_s = 1'b0;
    {rx0_red, rx0_green, rx0_blue} = '0;
    #12;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== 48'd0) $display("FAIL reset_din: got %h, required 0", fifo_din); else passed++;
    total++; if (seg_idx !== 4'd0) $display("FAIL reset_seg_idx: got %0d, required 0", seg_idx); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); else passed++;
    @(posedge clk); #1;
    rstbtn_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_full_line;
    int w0;
    w0 = wr_cnt;
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(hdr(5, s));
      for (int k = 0; k < 320; k++) begin
        int p;
        p = s * 640 + 2 * k;
        exp_q.push_back({24'(p), 24'(p + 1)});
      end
    end
    for (int i = 0; i < 1280; i++) begin
      @(posedge clk); #1;
      if (i == 639) begin
        total++; if (seg_idx !== 4'd0) $display("FAIL seg_idx_before_end: got %0d, required 0", seg_idx); else passed++;
      end
      if (i == 640 || i == 700) begin
        total++; if (seg_idx !== 4'd1) $display("FAIL seg_idx_seg1: got %0d, required 1", seg_idx); else passed++;
      end
      video_en = 1'b1; video_vcnt = 11'd5; fifo_full = 1'b0;
      {rx0_red, rx0_green, rx0_blue} = 24'(i);
    end
    @(posedge clk); #1;
    video_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (wr_cnt - w0 !== 642) $display("FAIL full_line_writes: got %0d, required 642", wr_cnt - w0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL full_line_pending: got %0d left, required 0", exp_q.size()); else passed++;
    total++; if (seg_idx !== 4'd0) $display("FAIL full_line_seg_idx_end: got %0d, required 0", seg_idx); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL full_line_drop_cnt: got %0d, required 0", drop_cnt); else passed++;
  endtask

  task automatic test_hdr_full;
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(hdr(7, 1));
    for (int k = 0; k < 320; k++) exp_q.push_back({24'(640 + 2 * k), 24'(641 + 2 * k)});
    drive_line(1280, 7, 0);
    total++; if (wr_cnt - w0 !== 321) $display("FAIL hdr_full_writes: got %0d, required 321", wr_cnt - w0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL hdr_full_pending: got %0d left, required 0", exp_q.size()); else passed++;
    total++; if (drop_cnt !== 16'd1) $display("FAIL hdr_full_drop_cnt: got %0d, required 1", drop_cnt); else passed++;
  endtask

  task automatic test_mid_full;
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(hdr(8, 0));
    for (int k = 0; k < 50; k++) exp_q.push_back({24'(2 * k), 24'(2 * k + 1)});
    exp_q.push_back(hdr(8, 1));
    for (int k = 0; k < 320; k++) exp_q.push_back({24'(640 + 2 * k), 24'(641 + 2 * k)});
    drive_line(1280, 8, 101);
    total++; if (wr_cnt - w0 !== 372) $display("FAIL mid_full_writes: got %0d, required 372", wr_cnt - w0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL mid_full_pending: got %0d left, required 0", exp_q.size()); else passed++;
    total++; if (drop_cnt !== 16'd2) $display("FAIL mid_full_drop_cnt: got %0d, required 2", drop_cnt); else passed++;
  endtask

  task automatic test_odd_flush;
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(hdr(3, 0));
    exp_q.push_back({24'd0, 24'd1});
    exp_q.push_back({24'd2, 24'd3});
    exp_q.push_back({24'd4, 24'd5});
    exp_q.push_back({24'd6, 24'h0});
    drive_line(7, 3, -1);
    total++; if (wr_cnt - w0 !== 5) $display("FAIL odd_flush_writes: got %0d, required 5", wr_cnt - w0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL odd_flush_pending: got %0d left, required 0", exp_q.size()); else passed++;
    total++; if (seg_idx !== 4'd0) $display("FAIL odd_flush_seg_idx: got %0d, required 0", seg_idx); else passed++;
  endtask

  task automatic test_async_reset;
    int w0;
    exp_q.push_back(hdr(4, 0));
    for (int k = 0; k < 25; k++) exp_q.push_back({24'(2 * k), 24'(2 * k + 1)});
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      video_en = 1'b1; video_vcnt = 11'd4; fifo_full = 1'b0;
      {rx0_red, rx0_green, rx0_blue} = 24'(i);
    end
    @(posedge clk);
    @(negedge clk); #1;
    rstbtn_n = 1'b0;
    #1;
    total++; if (fifo_wr_en !== 1'b0) $display("FAIL async_rst_wr_en: got %b, required 0", fifo_wr_en); else passed++;
    total++; if (fifo_din !== 48'd0) $display("FAIL async_rst_din: got %h, required 0", fifo_din); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("FAIL async_rst_drop_cnt: got %0d, required 0", drop_cnt); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL async_rst_pending: got %0d left, required 0", exp_q.size()); else passed++;
    @(posedge clk); #1;
    rstbtn_n = 1'b1;
    w0 = wr_cnt;
    for (int i = 50; i < 70; i++) begin
      @(posedge clk); #1;
      {rx0_red, rx0_green, rx0_blue} = 24'(i);
    end
    @(posedge clk); #1;
    video_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_cnt - w0 !== 0) $display("FAIL async_rst_no_writes: got %0d, required 0", wr_cnt - w0); else passed++;
    w0 = wr_cnt;
    exp_q.push_back(hdr(9, 0));
    exp_q.push_back({24'd0, 24'd1});
    exp_q.push_back({24'd2, 24'd3});
    drive_line(4, 9, -1);
    total++; if (wr_cnt - w0 !== 3) $display("FAIL async_rst_restart_writes: got %0d, required 3", wr_cnt - w0); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL async_rst_restart_pending: got %0d left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_drop_saturate;
    @(posedge clk_s); #1;
    video_en_s = 1'b1;
    repeat (131068) @(posedge clk_s);
    #1;
    total++; if (drop_cnt_s !== 16'hFFFE) $display("FAIL sat_drop_cnt_65534: got %h, required fffe", drop_cnt_s); else passed++;
    repeat (12) @(posedge clk_s);
    #1;
    total++; if (drop_cnt_s !== 16'hFFFF) $display("FAIL sat_drop_cnt_65540: got %h, required ffff", drop_cnt_s); else passed++;
    video_en_s = 1'b0;
    repeat (4) @(posedge clk_s);
    #1;
    total++; if (drop_cnt_s !== 16'hFFFF) $display("FAIL sat_drop_cnt_hold: got %h, required ffff", drop_cnt_s); else passed++;
    total++; if (wr_cnt_s !== 0) $display("FAIL sat_writes: got %0d, required 0", wr_cnt_s); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_hdr_full();
    test_mid_full();
    test_odd_flush();
    test_async_reset();
    test_drop_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
